// File: rtl/fifo_read_port_if.sv
// Read-domain bundle between the FIFO read controller, the FIFO memory,
// the write-pointer synchronizer and the downstream consumer.
interface fifo_read_port_if #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 8
) ();
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DATASIZE-1:0] rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [ADDRSIZE:0]   rlevel;

  // The read controller drives the memory address, pointer, flags and output word.
  modport master (
    input  rq2_wptr, rdata, dout_ready,
    output raddr, rptr, rempty, dout, dout_valid, rlevel
  );

  modport slave (
    output rq2_wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, dout, dout_valid, rlevel
  );
endinterface

// File: rtl/fifo_read_port.sv
// Read-side controller of the dual-clock FIFO: read pointer, empty flag, level
// and a registered first-word-fall-through output stage, all on rclk.
module fifo_read_port #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  fifo_read_port_if.master bus
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_STREAM
  } out_state_e;

  out_state_e          out_state;
  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   rbinnext;
  logic [ADDRSIZE:0]   rgraynext;
  logic [ADDRSIZE:0]   wbin;
  logic [ADDRSIZE:0]   rptr_q;
  logic [ADDRSIZE:0]   rlevel_q;
  logic                rempty_q;
  logic                dout_valid_q;
  logic [DATASIZE-1:0] dout_q;
  logic                rinc;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pop only when memory holds a word and the output slot is free or draining.
  assign rinc      = !rempty_q && ((out_state == ST_EMPTY) || bus.dout_ready);
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rinc};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign wbin      = gray2bin(bus.rq2_wptr);

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin         <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      rlevel_q     <= '0;
      // NOTE: the output word is a single register, not a memory, so it is
      // cleared on reset to give a defined dout; the FIFO array itself is not.
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      out_state    <= ST_EMPTY;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= (rgraynext == bus.rq2_wptr);
      rlevel_q <= wbin - rbinnext;

      if (rinc) begin
        dout_q       <= bus.rdata;
        dout_valid_q <= 1'b1;
        out_state    <= (out_state == ST_EMPTY) ? ST_HOLD : ST_STREAM;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
        out_state    <= ST_EMPTY;
      end else if (out_state == ST_STREAM) begin
        out_state <= ST_HOLD;
      end
    end
  end

  assign bus.raddr      = rbin[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.rlevel     = rlevel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port: directed vector table, randomized streams against
// an occupancy/scoreboard model, and a mid-stream reset sequence.
module tb_fifo_read_port;
  localparam int DW = 16;
  localparam int AW = 8;

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_read_port_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  fifo_read_port #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:255];
  assign bus.rdata = mem[bus.raddr];

  int checks = 0;
  int errors = 0;

  // Write-side and reference-model state (absolute counts since last reset).
  int          pushed = 0;
  int          pops = 0;
  int          consumed = 0;
  bit          m_valid = 1'b0;
  bit          m_empty = 1'b1;
  bit          seen_wrap = 1'b0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          rst;
    int            push;
    logic          ready;
    logic          exp_valid;
    logic [DW-1:0] exp_dout;
    logic          exp_rempty;
    logic [8:0]    exp_rptr;
    logic [8:0]    exp_rlevel;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] b2g(input int b);
    logic [8:0] x;
    x = 9'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [8:0] g2b(input logic [8:0] g);
    logic [8:0] b;
    b = '0;
    for (int i = 8; i >= 0; i--) begin
      b[i] = g[i] ^ ((i == 8) ? 1'b0 : b[i+1]);
    end
    return b;
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    logic [8:0] wb;
    wb = 9'(pushed);
    mem[wb[7:0]] = w;
    exp_q.push_back(w);
    pushed++;
    bus.rq2_wptr = b2g(pushed);
  endtask

  // One clock of the behavioural model: a word leaves memory whenever memory
  // is known non-empty and the output slot is free or being taken.
  task automatic model_edge(input logic rdy);
    bit pop;
    pop     = !m_empty && (!m_valid || rdy);
    pops    = pops + (pop ? 1 : 0);
    m_valid = pop || (m_valid && !rdy);
    m_empty = (pushed == pops);
  endtask

  task automatic run_stream(input int n, input int ready_pct, input bit index_pattern);
    int            sent;
    int            got;
    int            cyc;
    logic          rdy;
    logic          pre_v;
    logic [DW-1:0] pre_d;
    logic [8:0]    prev_rptr;
    logic [8:0]    occ;
    logic [DW-1:0] w;
    logic [DW-1:0] exp_w;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < 20000) begin
      occ = 9'(pushed) - g2b(bus.rptr);
      if (sent < n && occ < 9'd256 && (index_pattern || $urandom_range(1, 0) == 1)) begin
        w = index_pattern ? 16'(sent) : 16'($urandom);
        push_word(w);
        sent++;
      end
      rdy = ($urandom_range(99, 0) < ready_pct);
      bus.dout_ready = rdy;
      pre_v     = m_valid;
      pre_d     = bus.dout;
      prev_rptr = bus.rptr;
      @(posedge rclk);
      #1;
      cyc++;
      model_edge(rdy);
      if (pre_v && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected none", pre_d);
        end else begin
          exp_w = exp_q.pop_front();
          check("stream_data", pre_d, exp_w);
        end
        got++;
        consumed++;
      end else if (pre_v) begin
        check("hold_stable", bus.dout, pre_d);
      end
      check("dout_valid", bus.dout_valid, m_valid);
      check("rptr", bus.rptr, b2g(pops));
      check("rlevel", bus.rlevel, 9'(pushed - pops));
      check("rempty", bus.rempty, m_empty);
      if (prev_rptr == 9'h100 && bus.rptr == 9'h000) seen_wrap = 1'b1;
    end
    check("stream_words", got, n);
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] rb;
    logic [DW-1:0] w;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    rrst           = 1'b1;
    bus.rq2_wptr   = '0;
    bus.dout_ready = 1'b0;

    //              rst push rdy  val  dout      emp  rptr    rlevel
    vecs[0]  = '{1'b1, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h000, 9'd0};
    vecs[1]  = '{1'b1, 0, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h000, 9'd0};
    vecs[2]  = '{1'b0, 1, 1'b1, 1'b0, 16'h0000, 1'b0, 9'h000, 9'd1};
    vecs[3]  = '{1'b0, 0, 1'b1, 1'b1, 16'hA5A5, 1'b1, 9'h001, 9'd0};
    vecs[4]  = '{1'b0, 0, 1'b1, 1'b0, 16'hA5A5, 1'b1, 9'h001, 9'd0};
    vecs[5]  = '{1'b0, 4, 1'b0, 1'b0, 16'hA5A5, 1'b0, 9'h001, 9'd4};
    vecs[6]  = '{1'b0, 0, 1'b0, 1'b1, 16'h0001, 1'b0, 9'h003, 9'd3};
    for (int i = 7; i <= 15; i++) vecs[i] = vecs[6];
    vecs[16] = '{1'b0, 0, 1'b1, 1'b1, 16'h0002, 1'b0, 9'h002, 9'd2};
    vecs[17] = '{1'b0, 0, 1'b1, 1'b1, 16'h0003, 1'b0, 9'h006, 9'd1};
    vecs[18] = '{1'b0, 0, 1'b1, 1'b1, 16'h0004, 1'b1, 9'h007, 9'd0};
    vecs[19] = '{1'b0, 0, 1'b1, 1'b0, 16'h0004, 1'b1, 9'h007, 9'd0};

    // Directed table: reset, single word, backpressure with 4 pending words.
    for (int i = 0; i < 20; i++) begin
      rrst = vecs[i].rst;
      for (int k = 0; k < vecs[i].push; k++) begin
        w = (pushed == 0) ? 16'hA5A5 : 16'(pushed);
        push_word(w);
      end
      bus.dout_ready = vecs[i].ready;
      @(posedge rclk);
      #1;
      check($sformatf("vec%0d_valid", i), bus.dout_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_rempty", i), bus.rempty, vecs[i].exp_rempty);
      check($sformatf("vec%0d_rptr", i), bus.rptr, vecs[i].exp_rptr);
      check($sformatf("vec%0d_rlevel", i), bus.rlevel, vecs[i].exp_rlevel);
      rb = g2b(vecs[i].exp_rptr);
      check($sformatf("vec%0d_raddr", i), bus.raddr, rb[7:0]);
    end

    // Table drained all five words; align the model with that state.
    exp_q.delete();
    pops     = 5;
    consumed = 5;
    m_valid  = 1'b0;
    m_empty  = 1'b1;

    // Wrap: 600 index-pattern words at full throughput.
    run_stream(600, 100, 1'b1);
    check("gray_wrap_seen", seen_wrap, 1'b1);

    // Random backpressure: 1000 random words, ready 50%.
    run_stream(1000, 50, 1'b0);

    // Mid-stream reset with one word held and five still in memory.
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_word(16'h1000 + 16'(k));
    repeat (2) @(posedge rclk);
    #1;
    check("pre_reset_valid", bus.dout_valid, 1'b1);
    check("pre_reset_rlevel", bus.rlevel, 9'd5);

    rrst         = 1'b1;
    pushed       = 0;
    bus.rq2_wptr = '0;
    exp_q.delete();
    @(posedge rclk);
    #1;
    check("rst_valid", bus.dout_valid, 1'b0);
    check("rst_dout", bus.dout, 16'h0000);
    check("rst_rempty", bus.rempty, 1'b1);
    check("rst_rptr", bus.rptr, 9'h000);
    check("rst_rlevel", bus.rlevel, 9'd0);
    check("rst_raddr", bus.raddr, 8'h00);

    rrst           = 1'b0;
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge rclk);
      #1;
      check($sformatf("post_rst_idle%0d", c), bus.dout_valid, 1'b0);
    end

    push_word(16'hBEEF);
    @(posedge rclk);
    #1;
    check("post_rst_rempty", bus.rempty, 1'b0);
    check("post_rst_valid0", bus.dout_valid, 1'b0);
    @(posedge rclk);
    #1;
    check("post_rst_valid1", bus.dout_valid, 1'b1);
    check("post_rst_dout", bus.dout, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
